lab5_if_stage: RTL and testbench
================================

LAB5_IF_STAGE -- requirements
Module: lab5_if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 stall_i  input  1  SHALL mean the ID stage cannot accept: hold IF/ID outputs.
REQ-005 redirect_i  input  1  SHALL mean a taken branch/jump resolved downstream: refetch from redirect_pc_i.
REQ-006 redirect_pc_i  input  32  SHALL be the redirect target; bits [1:0] ignored and treated as 0.
REQ-007 imem_req_o  output  1  SHALL be the instruction-memory request strobe.
REQ-008 imem_addr_o  output  32  SHALL be the fetch address, word-aligned.
REQ-009 imem_ack_i  input  1  SHALL mean imem_rdata_i is valid for the current request this cycle.
REQ-010 imem_rdata_i  input  32  SHALL be the fetched instruction word.
REQ-011 ifid_valid_o  output  1  SHALL mark ifid_pc_o/ifid_instr_o as a real instruction (0 = bubble).
REQ-012 ifid_pc_o  output  32  SHALL be the PC of the instruction in IF/ID.
REQ-013 ifid_instr_o  output  32  SHALL be the instruction word in IF/ID, fed to ID decode and immediate generation.

Function
REQ-014 States SHALL be IDLE, REQ, HOLD, DROP; IDLE is entered only by reset and exits to REQ on the next cycle.
REQ-015 In REQ and DROP imem_req_o SHALL be 1; in IDLE and HOLD it SHALL be 0.
REQ-016 imem_addr_o SHALL equal pc in REQ and remain stable until imem_ack_i; it SHALL be driven while imem_req_o=1.
REQ-017 REQ, ack, no redirect, no stall: IF/ID SHALL load {1, pc, imem_rdata_i}, pc SHALL advance to next-pc (REQ-032/033), state stays REQ; back-to-back fetch one instruction per cycle when memory acks every cycle.
REQ-018 REQ, ack, stall_i=1, no redirect: word SHALL be captured in a one-entry hold buffer with its pc; IF/ID unchanged; go to HOLD.
REQ-019 HOLD, stall_i=0, no redirect: IF/ID SHALL load hold buffer with valid=1, pc advances, go to REQ.
REQ-020 REQ, no ack, no stall: ifid_valid_o SHALL become 0 (bubble); pc and IF/ID pc/instr values held.
REQ-021 Any state with stall_i=1 and no redirect: ifid_valid_o, ifid_pc_o, ifid_instr_o SHALL hold.
REQ-022 redirect_i SHALL take priority over stall_i and ack; next cycle ifid_valid_o=0 regardless of stall_i.
REQ-023 redirect_i in REQ with ack same cycle, or in HOLD/IDLE: returned/buffered word discarded, pc<=target, state REQ.
REQ-024 redirect_i in REQ without ack: target SHALL be saved, state DROP; request stays asserted at old address.
REQ-025 DROP: on ack the word SHALL be discarded, pc<=saved target, go to REQ; a further redirect in DROP SHALL overwrite the saved target.
REQ-026 In DROP ifid_valid_o SHALL remain 0.
REQ-027 pc arithmetic SHALL be 32-bit modulo 2^32; pc 32'hFFFF_FFFC + 4 wraps to 0.
REQ-028 imem_rdata_i SHALL be sampled only on the ack cycle; no combinational path from imem_rdata_i to any output.

Reset
REQ-029 When rst=1 at a clock edge: state IDLE, pc=RESET_PC, ifid_valid_o=0, ifid_pc_o=0, ifid_instr_o=0, hold buffer cleared, saved target cleared.
REQ-030 rst SHALL override redirect_i, stall_i and imem_ack_i; an ack arriving during or on the cycle of reset SHALL be discarded.
REQ-031 Reset mid-request SHALL abandon the request; first post-reset request at RESET_PC on the second cycle after rst deasserts.

Configuration
REQ-032 Macro IF_JAL_PREDECODE_EN defined: for an accepted word with opcode[6:0]=7'b1101111, next pc SHALL be pc + sign-extend({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}); other opcodes pc+4.
REQ-033 Macro undefined: next pc SHALL always be pc+4; JAL redirect comes only via redirect_i.

Verification
REQ-034 Reset with RESET_PC=32'h100, ack every cycle, words 0x00000013: IF/ID pcs 0x100,0x104,0x108 on consecutive cycles, valid=1.
REQ-035 stall_i high 3 cycles while ack returns word at pc 0x104: IF/ID holds 0x100 entry; after release 0x104 appears exactly once, no skip/duplicate.
REQ-036 redirect_i=1, redirect_pc_i=0x203 while request to 0x108 pending without ack: DROP, ack discarded, next request addr 0x200, ifid_valid_o=0 throughout.
REQ-037 redirect_i and stall_i together: next cycle ifid_valid_o=0, fetch resumes at target.
REQ-038 With IF_JAL_PREDECODE_EN, word 0x0080006F (jal x0,+8) at pc 0x100: next imem_addr_o 0x108; without the macro 0x104.
REQ-039 rst asserted while request outstanding and ack on the same cycle: outputs all 0, word dropped, refetch at RESET_PC.

Source files
------------

// File: rtl/lab5_if_stage.sv
// Instruction-fetch stage: single-outstanding imem request FSM feeding the IF/ID register.
// Optional JAL predecode steering of the next pc under IF_JAL_PREDECODE_EN.
module lab5_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_instr_o
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, hold_pc, hold_instr, tgt;
  logic [31:0] redir_pc, acc_pc, acc_instr, pc_seq;

  assign redir_pc = {redirect_pc_i[31:2], 2'b00};
  wire unused_redir_lsb = ^redirect_pc_i[1:0];

  // the word being accepted comes from memory in REQ, from the hold buffer in HOLD
  assign acc_pc    = (state == HOLD) ? hold_pc    : pc;
  assign acc_instr = (state == HOLD) ? hold_instr : imem_rdata_i;

`ifdef IF_JAL_PREDECODE_EN
  logic [31:0] jal_imm, jal_tgt;
  assign jal_imm = {{11{acc_instr[31]}}, acc_instr[31], acc_instr[19:12],
                    acc_instr[20], acc_instr[30:21], 1'b0};
  assign jal_tgt = acc_pc + jal_imm;
  assign pc_seq  = (acc_instr[6:0] == 7'b1101111) ? {jal_tgt[31:2], 2'b00}
                                                  : acc_pc + 32'd4;
  wire unused_jal_lsb = ^jal_tgt[1:0];
`else
  assign pc_seq = acc_pc + 32'd4;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (redirect_i)                 state_nxt = imem_ack_i ? REQ : DROP;
        else if (imem_ack_i && stall_i) state_nxt = HOLD;
      end
      HOLD: if (redirect_i || !stall_i) state_nxt = REQ;
      DROP: if (imem_ack_i)             state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req_o  = (state == REQ) || (state == DROP);
    imem_addr_o = pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= {RESET_PC[31:2], 2'b00};
      ifid_valid_o <= 1'b0;
      ifid_pc_o    <= '0;
      ifid_instr_o <= '0;
      hold_pc      <= '0;
      hold_instr   <= '0;
      tgt          <= '0;
    end else begin
      case (state)
        IDLE: if (redirect_i) begin
          pc           <= redir_pc;
          ifid_valid_o <= 1'b0;
        end
        REQ: begin
          if (redirect_i) begin
            ifid_valid_o <= 1'b0;
            if (imem_ack_i) pc  <= redir_pc;
            else            tgt <= redir_pc;
          end else if (imem_ack_i) begin
            if (stall_i) begin
              hold_pc    <= pc;
              hold_instr <= imem_rdata_i;
            end else begin
              ifid_valid_o <= 1'b1;
              ifid_pc_o    <= pc;
              ifid_instr_o <= imem_rdata_i;
              pc           <= pc_seq;
            end
          end else if (!stall_i) begin
            ifid_valid_o <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect_i) begin
            ifid_valid_o <= 1'b0;
            pc           <= redir_pc;
          end else if (!stall_i) begin
            ifid_valid_o <= 1'b1;
            ifid_pc_o    <= hold_pc;
            ifid_instr_o <= hold_instr;
            pc           <= pc_seq;
          end
        end
        DROP: begin
          // the in-flight word belongs to the squashed path; only its ack matters
          ifid_valid_o <= 1'b0;
          if (redirect_i) begin
            if (imem_ack_i) pc  <= redir_pc;
            else            tgt <= redir_pc;
          end else if (imem_ack_i) begin
            pc <= tgt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lab5_if_stage.sv
// Bench for lab5_if_stage: directed scenarios plus a random run scored against
// an instruction-stream model (expected program order, memory contents, hold rules).
module tb_lab5_if_stage;
  localparam logic [31:0] RPC = 32'h100;
`ifdef IF_JAL_PREDECODE_EN
  localparam logic [31:0] JAL_NEXT = 32'h108;
`else
  localparam logic [31:0] JAL_NEXT = 32'h104;
`endif

  logic        clk = 1'b0;
  logic        rst, stall_i, redirect_i, imem_ack_i;
  logic        imem_req_o, ifid_valid_o;
  logic [31:0] redirect_pc_i, imem_addr_o, imem_rdata_i, ifid_pc_o, ifid_instr_o;

  always #5 clk = ~clk;

  lab5_if_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i), .ifid_valid_o(ifid_valid_o),
    .ifid_pc_o(ifid_pc_o), .ifid_instr_o(ifid_instr_o)
  );

  int          errors = 0, checks = 0, consumed = 0;
  bit          mode13 = 0, jal_mode = 0, sb_en = 0;
  logic [31:0] exp_pc = RPC;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] h;
    h = (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    if (mode13) return 32'h0000_0013;
    if (jal_mode && a == 32'h100) return 32'h0080_006F;
    return {h[31:7], 7'b0010011};
  endfunction

  function automatic logic [31:0] tb_next(input logic [31:0] p, input logic [31:0] ins);
`ifdef IF_JAL_PREDECODE_EN
    int off;
    if (ins[6:0] == 7'b1101111) begin
      off = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      return (p + off) & 32'hFFFF_FFFC;
    end
`endif
    return p + 32'd4;
  endfunction

  task automatic drive(input bit r, input bit s, input bit rd, input logic [31:0] rpc, input bit ack);
    @(negedge clk);
    rst = r; stall_i = s; redirect_i = rd; redirect_pc_i = rpc; imem_ack_i = ack;
    imem_rdata_i = ack ? mem(imem_addr_o) : $urandom;
  endtask

  // one clock edge; when the scoreboard is on, judge the edge against the stream model
  task automatic cyc();
    bit          s_rst, s_stall, s_rd, s_ack, s_valid, s_req;
    logic [31:0] s_rpc, s_pc, s_instr, s_addr;
    s_rst = rst; s_stall = stall_i; s_rd = redirect_i; s_ack = imem_ack_i; s_rpc = redirect_pc_i;
    s_valid = ifid_valid_o; s_pc = ifid_pc_o; s_instr = ifid_instr_o;
    s_req = imem_req_o; s_addr = imem_addr_o;
    @(posedge clk); #1;
    if (!sb_en) return;
    chk("addr_align", {30'd0, imem_addr_o[1:0] & {2{imem_req_o}}}, 32'd0);
    if (s_rst) begin
      chk("sb_rst_valid", ifid_valid_o, 0);
      chk("sb_rst_req", imem_req_o, 0);
      exp_pc = RPC;
    end else if (s_rd) begin
      chk("sb_redir_bubble", ifid_valid_o, 0);
      exp_pc = s_rpc & 32'hFFFF_FFFC;
    end else begin
      if (s_valid && !s_stall) begin
        chk("sb_pc", s_pc, exp_pc);
        chk("sb_instr", s_instr, mem(s_pc));
        exp_pc = tb_next(exp_pc, s_instr);
        consumed++;
      end
      if (s_stall) begin
        chk("sb_hold_valid", ifid_valid_o, s_valid);
        chk("sb_hold_pc", ifid_pc_o, s_pc);
        chk("sb_hold_instr", ifid_instr_o, s_instr);
      end
      if (s_req && !s_ack) begin
        chk("sb_req_kept", imem_req_o, 1);
        chk("sb_addr_stable", imem_addr_o, s_addr);
      end
    end
  endtask

  initial begin
    // reset with a stray ack present
    drive(1, 0, 0, 0, 1); cyc();
    drive(1, 0, 0, 0, 1); cyc();
    chk("rst_valid", ifid_valid_o, 0);
    chk("rst_pc", ifid_pc_o, 0);
    chk("rst_instr", ifid_instr_o, 0);
    chk("rst_req", imem_req_o, 0);
    drive(0, 0, 0, 0, 0);
    chk("idle_req", imem_req_o, 0);
    cyc();
    chk("first_req", imem_req_o, 1);
    chk("first_addr", imem_addr_o, RPC);

    // back-to-back fetch
    mode13 = 1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1); cyc();
      chk("b2b_valid", ifid_valid_o, 1);
      chk("b2b_pc", ifid_pc_o, RPC + 4 * i);
      chk("b2b_instr", ifid_instr_o, 32'h13);
    end

    // stall while the next word returns
    drive(1, 0, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 1); cyc();
    chk("st_pc0", ifid_pc_o, 32'h100);
    chk("st_addr", imem_addr_o, 32'h104);
    drive(0, 1, 0, 0, 1); cyc();
    chk("st_hold_pc", ifid_pc_o, 32'h100);
    chk("st_hold_req", imem_req_o, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0, 0); cyc();
      chk("st_hold_valid", ifid_valid_o, 1);
      chk("st_hold_pc2", ifid_pc_o, 32'h100);
    end
    drive(0, 0, 0, 0, 0); cyc();
    chk("st_rel_valid", ifid_valid_o, 1);
    chk("st_rel_pc", ifid_pc_o, 32'h104);
    chk("st_rel_addr", imem_addr_o, 32'h108);
    drive(0, 0, 0, 0, 0); cyc();
    chk("st_nodup", ifid_valid_o, 0);

    // redirect with request pending: drop the returning word
    drive(0, 0, 1, 32'h203, 0); cyc();
    chk("drop_valid", ifid_valid_o, 0);
    chk("drop_addr", imem_addr_o, 32'h108);
    chk("drop_req", imem_req_o, 1);
    drive(0, 0, 0, 0, 0); cyc();
    chk("drop_valid2", ifid_valid_o, 0);
    drive(0, 0, 0, 0, 1); cyc();
    chk("drop_ack_valid", ifid_valid_o, 0);
    chk("drop_new_addr", imem_addr_o, 32'h200);

    // redirect + stall + ack together, target near the top of memory
    drive(0, 1, 1, 32'hFFFF_FFFE, 1); cyc();
    chk("rs_valid", ifid_valid_o, 0);
    chk("rs_addr", imem_addr_o, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 1); cyc();
    chk("wrap_pc", ifid_pc_o, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr_o, 32'h0);

    // reset during an acked request
    drive(1, 0, 0, 0, 1); cyc();
    chk("rr_valid", ifid_valid_o, 0);
    chk("rr_pc", ifid_pc_o, 0);
    chk("rr_instr", ifid_instr_o, 0);
    chk("rr_req", imem_req_o, 0);
    drive(0, 0, 0, 0, 1); cyc();
    chk("rr_refetch", imem_addr_o, RPC);
    chk("rr_valid2", ifid_valid_o, 0);

    // JAL at the reset pc
    mode13 = 0; jal_mode = 1;
    drive(0, 0, 0, 0, 1); cyc();
    chk("jal_instr", ifid_instr_o, 32'h0080_006F);
    chk("jal_next", imem_addr_o, JAL_NEXT);

    // random run against the stream model
    jal_mode = 0; sb_en = 1;
    drive(1, 0, 0, 0, 0); cyc();
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] t;
      t = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h000F_FFFF);
      drive($urandom % 300 == 0, $urandom % 4 == 0, $urandom % 12 == 0, t, $urandom % 3 != 0);
      cyc();
    end
    chk("progress", consumed > 200, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
